bcd2binary: RTL and testbench

BCD2BINARY -- requirements
Module: bcd2binary

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd2binary_if.sv | 26 ++
 rtl/bcd_mac10.sv | 20 ++
 rtl/bcd2binary.sv | 98 +++++++++
 tb/tb_bcd2binary.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// State encoding is exposed on the debug port: IDLE=0, CONV=1, DONE=2.
package bcd_pkg;

    localparam int BIN_W   = 14;
    localparam int DIGITS  = 4;
    localparam int BCD_MAX = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic digit_bad(input logic [3:0] d);
        return d > 4'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd2binary_if.sv
// Request/result bundle of the BCD-to-binary converter.
// master: start + four BCD digits out, result/status in; slave: the converter.
interface bcd2binary_if;
    import bcd_pkg::*;

    logic             start;
    logic [3:0]       bcd3;
    logic [3:0]       bcd2;
    logic [3:0]       bcd1;
    logic [3:0]       bcd0;
    logic [BIN_W-1:0] out;
    logic             ready;
    logic             done_tick;
    logic             err;

    modport master (
        output start, bcd3, bcd2, bcd1, bcd0,
        input  out, ready, done_tick, err
    );

    modport slave (
        input  start, bcd3, bcd2, bcd1, bcd0,
        output out, ready, done_tick, err
    );

endinterface

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add: sum = acc*10 + digit, mod 2^14.
// Ports: acc[13:0], digit[3:0] in; sum[13:0] out.
module bcd_mac10
    import bcd_pkg::*;
(
    input  logic [BIN_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [BIN_W-1:0] sum
);

    localparam int W = 18;

    logic [W-1:0] w_ext;

    assign w_ext = {4'b0, acc};

    // x10 as shift-add at 18 bits, then truncated back to the result width
    assign sum = BIN_W'((w_ext << 3) + (w_ext << 1) + W'(digit));

endmodule

// File: rtl/bcd2binary.sv
// Four-digit BCD to 14-bit binary converter, one digit per cycle (MSD first).
// Ports: clk, reset (sync, active-high), bus (bcd2binary_if.slave:
// start, bcd3..bcd0 in; out, ready, done_tick, err out), state/count debug.
// Optional macro BCD2BIN_ERRCHK_EN: reject digits > 9 with err=1, out=0.
module bcd2binary
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    bcd2binary_if.slave bus,
    output logic [1:0] state,
    output logic [1:0] count
);

    state_t                r_state;
    logic [1:0]            r_count;
    logic [BIN_W-1:0]      r_acc;
    logic [BIN_W-1:0]      r_out;
    logic [DIGITS-1:0][3:0] r_dig;
    logic                  r_done;
    logic                  r_err;

    logic [3:0]            w_digit;
    logic [BIN_W-1:0]      w_sum;
    logic                  w_bad;

    assign w_digit = r_dig[r_count];

    bcd_mac10 u_mac (
        .acc   (r_acc),
        .digit (w_digit),
        .sum   (w_sum)
    );

`ifdef BCD2BIN_ERRCHK_EN
    assign w_bad = digit_bad(bus.bcd3) | digit_bad(bus.bcd2)
                 | digit_bad(bus.bcd1) | digit_bad(bus.bcd0);
`else
    assign w_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= 2'd0;
            r_acc   <= '0;
            r_out   <= '0;
            r_dig   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_dig   <= {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
                        r_acc   <= '0;
                        r_count <= 2'd3;
                        r_err   <= 1'b0;
                        if (w_bad) begin
                            // bad digit: skip conversion, report at once
                            r_err   <= 1'b1;
                            r_out   <= '0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= CONV;
                        end
                    end
                end
                CONV: begin
                    r_acc <= w_sum;
                    if (r_count == 2'd0) begin
                        r_out   <= w_sum;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_count <= r_count - 2'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = (r_state == IDLE);
    assign bus.out       = r_out;
    assign bus.done_tick = r_done;
    assign bus.err       = r_err;
    assign state         = r_state;
    assign count         = r_count;

endmodule

// File: tb/tb_bcd2binary.sv
// Directed bench for bcd2binary: reset, conversions, input isolation,
// aborts, invalid digits and back-to-back streaming.
module tb_bcd2binary;
    import bcd_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state;
    logic [1:0] count;

    bcd2binary_if bus();

    bcd2binary dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .state (state),
        .count (count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int dcnt   = 0;
    int d0;

    always @(posedge clk) if (bus.done_tick === 1'b1) dcnt++;

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic setd(logic [3:0] a, logic [3:0] b,
                        logic [3:0] c, logic [3:0] d);
        bus.bcd3 = a;
        bus.bcd2 = b;
        bus.bcd1 = c;
        bus.bcd0 = d;
    endtask

    // start pulse at cycle N, result expected at N+5
    task automatic run(string tag, logic [3:0] a, logic [3:0] b,
                       logic [3:0] c, logic [3:0] d, int exp);
        int base;
        base = dcnt;
        setd(a, b, c, d);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(3);
        chk({tag, "_pre"}, 32'(bus.done_tick), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(bus.done_tick), 32'd1);
        chk({tag, "_out"}, 32'(bus.out), 32'(exp));
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        tick();
        chk({tag, "_ndone"}, 32'(dcnt - base), 32'd1);
        chk({tag, "_hold"}, 32'(bus.out), 32'(exp));
    endtask

    initial begin
        bus.start = 1'b0;
        setd(0, 0, 0, 0);
        reset = 1'b1;
        tick(3);
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done", 32'(bus.done_tick), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        reset = 1'b0;
        tick();

        // 1234 with step-by-step state checks
        d0 = dcnt;
        setd(1, 2, 3, 4);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("c1_state", 32'(state), 32'd1);
        chk("c1_count", 32'(count), 32'd3);
        chk("c1_ready", 32'(bus.ready), 32'd0);
        tick(3);
        chk("c1_pre", 32'(bus.done_tick), 32'd0);
        tick();
        chk("c1_done", 32'(bus.done_tick), 32'd1);
        chk("c1_out", 32'(bus.out), 32'd1234);
        chk("c1_err", 32'(bus.err), 32'd0);
        chk("c1_dstate", 32'(state), 32'd2);
        tick();
        chk("c1_after", 32'(bus.done_tick), 32'd0);
        chk("c1_ready2", 32'(bus.ready), 32'd1);
        chk("c1_ndone", 32'(dcnt - d0), 32'd1);

        run("c9999", 9, 9, 9, 9, 9999);
        run("c0000", 0, 0, 0, 0, 0);

        // inputs change mid-conversion
        setd(5, 0, 0, 7);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        setd(1, 1, 1, 1);
        tick(3);
        chk("iso_done", 32'(bus.done_tick), 32'd1);
        chk("iso_out", 32'(bus.out), 32'd5007);
        tick();

        // abort by reset at N+2
        d0 = dcnt;
        setd(8, 8, 8, 8);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ab_ready", 32'(bus.ready), 32'd1);
        chk("ab_out", 32'(bus.out), 32'd0);
        chk("ab_done", 32'(bus.done_tick), 32'd0);
        tick(6);
        chk("ab_ndone", 32'(dcnt - d0), 32'd0);
        run("c4321", 4, 3, 2, 1, 4321);

`ifdef BCD2BIN_ERRCHK_EN
        setd(1, 10, 0, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ec_done", 32'(bus.done_tick), 32'd1);
        chk("ec_err", 32'(bus.err), 32'd1);
        chk("ec_out", 32'(bus.out), 32'd0);
        tick();
        chk("ec_ready", 32'(bus.ready), 32'd1);
        chk("ec_errhold", 32'(bus.err), 32'd1);
        tick();
`else
        run("c1A00", 1, 10, 0, 0, 2000);
        run("cFFFF", 15, 15, 15, 15, 16665 % 16384);
`endif

        // reset wins over start
        setd(1, 1, 1, 1);
        bus.start = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.start = 1'b0;
        chk("pri_state", 32'(state), 32'd0);
        chk("pri_ready", 32'(bus.ready), 32'd1);
        tick();

        // start held high for 20 cycles
        d0 = dcnt;
        setd(0, 0, 4, 2);
        bus.start = 1'b1;
        for (int k = 1; k < 20; k++) begin
            tick();
            if (k == 5 || k == 11 || k == 17) begin
                chk($sformatf("st_done%0d", k), 32'(bus.done_tick), 32'd1);
                chk($sformatf("st_out%0d", k), 32'(bus.out), 32'd42);
            end else begin
                chk($sformatf("st_nd%0d", k), 32'(bus.done_tick), 32'd0);
            end
        end
        bus.start = 1'b0;
        tick(8);
        chk("st_ndone", 32'(dcnt - d0), 32'd4);
        chk("st_ready", 32'(bus.ready), 32'd1);
        chk("st_out", 32'(bus.out), 32'd42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
